// File: rtl/conv_result_framer.sv
// Frames a signed conv result stream into a full raster of 24-bit pixels:
// interior pixels carry the saturated or truncated |result|, and the 1-pixel border is a constant.
module conv_result_framer #(
  parameter int          IM_WIDTH     = 224,
  parameter int          IM_HEIGHT    = 224,
  parameter int          RESULT_WIDTH = 32,
  parameter logic [23:0] BORDER_PIXEL = 24'hFF0000,
  parameter bit          SATURATE     = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic signed [RESULT_WIDTH-1:0] result,
  input  logic                           resultValid,
  output logic                           out_accepting_values,
  input  logic                           out_full,
  output logic                           out_wr_en,
  output logic [23:0]                    out_din,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           drop_err
);

  localparam int CW = $clog2(IM_WIDTH);
  localparam int RW = $clog2(IM_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IM_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IM_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          drop_err_q;

  logic                    run;
  logic                    border;
  logic [RESULT_WIDTH-1:0] res_u;
  logic [RESULT_WIDTH-1:0] mag;
  logic                    hi_nz;
  logic [7:0]              pix8;
  logic                    drop_set;

  assign run    = (state_q == RUN);
  assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                  (col_q == '0) || (col_q == COL_LAST);

  // Two's-complement magnitude read as unsigned, so the most negative input maps to 2^(W-1).
  assign res_u = result;
  assign mag   = res_u[RESULT_WIDTH-1] ? (~res_u + RESULT_WIDTH'(1)) : res_u;
  assign hi_nz = |mag[RESULT_WIDTH-1:8];
  assign pix8  = (SATURATE && hi_nz) ? 8'hFF : mag[7:0];

  assign out_accepting_values = run && !border && !out_full;
  assign out_wr_en            = run && !out_full && (border || resultValid);
  assign out_din              = run ? (border ? BORDER_PIXEL : {3{pix8}}) : 24'h0;

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign drop_err   = drop_err_q;

  // Offering a result while the FIFO is full is a legitimate stall, so it is not treated as a drop.
  assign drop_set = resultValid && !out_full && !(run && !border);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN: begin
          if (out_wr_en) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q   <= '0;
                state_q <= DONE;
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (start && state_q == IDLE) drop_err_q <= 1'b0;
      else if (drop_set)            drop_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_result_framer.sv
// Bench for conv_result_framer on a 5x5 frame, running a saturating and a truncating instance in parallel.
module tb_conv_result_framer;

  localparam int W = 5;
  localparam int H = 5;
  localparam int NPIX = W * H;
  localparam int NINT = (W - 2) * (H - 2);
  localparam logic [23:0] BORDER = 24'hFF0000;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic signed [31:0] result;
  logic resultValid;
  logic out_full;

  logic acc1, wr1, busy1, fd1, drop1;
  logic [23:0] din1;
  logic acc0, wr0, busy0, fd0, drop0;
  logic [23:0] din0;

  always #5 clock = ~clock;

  conv_result_framer #(.IM_WIDTH(W), .IM_HEIGHT(H), .RESULT_WIDTH(32),
                       .BORDER_PIXEL(BORDER), .SATURATE(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .result(result),
    .resultValid(resultValid), .out_accepting_values(acc1), .out_full(out_full),
    .out_wr_en(wr1), .out_din(din1), .busy(busy1), .frame_done(fd1), .drop_err(drop1)
  );

  conv_result_framer #(.IM_WIDTH(W), .IM_HEIGHT(H), .RESULT_WIDTH(32),
                       .BORDER_PIXEL(BORDER), .SATURATE(1'b0)) dut_trunc (
    .clock(clock), .reset(reset), .start(start), .result(result),
    .resultValid(resultValid), .out_accepting_values(acc0), .out_full(out_full),
    .out_wr_en(wr0), .out_din(din0), .busy(busy0), .frame_done(fd0), .drop_err(drop0)
  );

  typedef struct {
    logic [23:0] sat;
    logic [23:0] trunc;
  } exp_t;

  exp_t q[$];
  logic signed [31:0] res_tab [NINT];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] pix(input logic signed [31:0] r, input bit sat);
    longint m;
    m = (r < 0) ? -longint'(r) : longint'(r);
    if (sat && m > 255) return 8'hFF;
    return m[7:0];
  endfunction

  // Runs one frame. pulse_cyc forces resultValid on a border cycle; abort_at asserts reset after that many writes.
  task automatic run_frame(input string name, input bit toggle_full, input int pulse_cyc,
                           input int abort_at, input logic exp_drop);
    int k, idx, writes, cyc, mrow, mcol;
    bit fd_pending, done;
    logic exp_border, exp_acc, exp_wr, exp_fd;
    exp_t e;
    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          e.sat = BORDER; e.trunc = BORDER;
        end else begin
          e.sat   = {3{pix(res_tab[k], 1'b1)}};
          e.trunc = {3{pix(res_tab[k], 1'b0)}};
          k++;
        end
        q.push_back(e);
      end
    end
    idx = 0; writes = 0; cyc = 0; mrow = 0; mcol = 0; fd_pending = 0; done = 0;
    @(posedge clock); #1;
    start = 1'b1; resultValid = 1'b0; out_full = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    while (!done && cyc < 300) begin
      out_full   = toggle_full && (((cyc >> 1) & 1) == 1);
      exp_border = (mrow == 0 || mrow == H - 1 || mcol == 0 || mcol == W - 1);
      resultValid = (writes < NPIX && !exp_border && idx < NINT) || (cyc == pulse_cyc);
      result = res_tab[(idx < NINT) ? idx : 0];
      @(negedge clock);
      if (cyc == 0) begin
        checks++;
        if (drop1 !== 1'b0 || drop0 !== 1'b0) begin
          errors++;
          $display("FAIL %s drop_clear_on_start: got %b/%b want 0", name, drop1, drop0);
        end
      end
      exp_acc = (writes < NPIX) && !exp_border && !out_full;
      exp_wr  = (writes < NPIX) && !out_full && (exp_border || resultValid);
      exp_fd  = fd_pending;
      checks++;
      if (acc1 !== exp_acc || acc0 !== exp_acc) begin
        errors++;
        $display("FAIL %s accepting cyc%0d: got %b/%b want %b", name, cyc, acc1, acc0, exp_acc);
      end
      checks++;
      if (wr1 !== exp_wr || wr0 !== exp_wr) begin
        errors++;
        $display("FAIL %s wr_en cyc%0d: got %b/%b want %b", name, cyc, wr1, wr0, exp_wr);
      end
      checks++;
      if (fd1 !== exp_fd || fd0 !== exp_fd || busy1 !== 1'b1 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL %s done_busy cyc%0d: fd %b/%b busy %b/%b want fd %b busy 1",
                 name, cyc, fd1, fd0, busy1, busy0, exp_fd);
      end
      if (exp_fd) done = 1;
      if (wr1 === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (din1 !== e.sat || din0 !== e.trunc) begin
          errors++;
          $display("FAIL %s pixel(%0d,%0d): got %h/%h want %h/%h",
                   name, mrow, mcol, din1, din0, e.sat, e.trunc);
        end else begin
          $display("%s write %0d (%0d,%0d) din %h/%h", name, writes, mrow, mcol, din1, din0);
        end
        writes++;
        if (mcol == W - 1) begin mcol = 0; mrow++; end else mcol++;
        if (writes == NPIX) fd_pending = 1;
      end
      if (acc1 === 1'b1 && resultValid) idx++;
      if (writes == abort_at) begin
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({wr1, acc1, busy1, fd1, drop1} !== 5'b0 || din1 !== 24'h0 ||
            {wr0, acc0, busy0, fd0, drop0} !== 5'b0 || din0 !== 24'h0) begin
          errors++;
          $display("FAIL %s abort_outputs: got wr%b acc%b busy%b fd%b drop%b din%h want all 0",
                   name, wr1, acc1, busy1, fd1, drop1, din1);
        end
        resultValid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
          errors++;
          $display("FAIL %s abort_busy: got %b/%b want 0", name, busy1, busy0);
        end
        reset = 1'b1;
        $display("%s aborted after %0d writes", name, writes);
        q.delete();
        return;
      end
      @(posedge clock); #1;
      cyc++;
    end
    resultValid = 1'b0; out_full = 1'b0;
    checks++;
    if (!done || writes != NPIX || q.size() != 0) begin
      errors++;
      $display("FAIL %s frame_end: done %0d writes %0d left %0d want 1 %0d 0",
               name, done, writes, q.size(), NPIX);
    end
    q.delete();
    @(negedge clock);
    checks++;
    if (busy1 !== 1'b0 || fd1 !== 1'b0 || drop1 !== exp_drop || drop0 !== exp_drop) begin
      errors++;
      $display("FAIL %s idle_after: busy %b fd %b drop %b/%b want 0 0 %b",
               name, busy1, fd1, drop1, drop0, exp_drop);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; result = 32'sd0; resultValid = 1'b0; out_full = 1'b0;
    repeat (2) @(posedge clock);
    #1 start = 1'b1; resultValid = 1'b1;
    @(negedge clock);
    checks++;
    if ({wr1, acc1, busy1, fd1, drop1, wr0, acc0, busy0, fd0, drop0} !== 10'b0 ||
        din1 !== 24'h0 || din0 !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got wr%b acc%b busy%b fd%b drop%b din%h want all 0",
               wr1, acc1, busy1, fd1, drop1, din1);
    end
    start = 1'b0; resultValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy1 !== 1'b0 || drop1 !== 1'b0 || din1 !== 24'h0) begin
      errors++;
      $display("FAIL reset_release: busy %b drop %b din %h want 0 0 0", busy1, drop1, din1);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    for (int i = 0; i < NINT; i++) res_tab[i] = 32'(i + 1);
    run_frame("basic", 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_abs_saturate();
    res_tab[0] = -32'sd5;  res_tab[1] = 32'sd300; res_tab[2] = 32'sh80000000;
    res_tab[3] = 32'sd255; res_tab[4] = 32'sd0;   res_tab[5] = -32'sd1;
    res_tab[6] = 32'sd256; res_tab[7] = -32'sd256; res_tab[8] = -32'sd255;
    run_frame("abs_sat", 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < NINT; i++) res_tab[i] = 32'(i + 1);
    run_frame("backpressure", 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_drop_err();
    for (int i = 0; i < NINT; i++) res_tab[i] = 32'(i * 37 - 100);
    run_frame("drop_err", 1'b0, 1, -1, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (drop1 !== 1'b1 || drop0 !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky: got %b/%b want 1", drop1, drop0);
    end
  endtask

  task automatic test_start_clears();
    for (int i = 0; i < NINT; i++) res_tab[i] = 32'(1000 - i * 111);
    run_frame("start_clears", 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < NINT; i++) res_tab[i] = 32'(i + 1);
    run_frame("abort", 1'b0, -1, 12, 1'b0);
    for (int i = 0; i < NINT; i++) res_tab[i] = 32'(-(i + 20));
    run_frame("after_abort", 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abs_saturate();
    test_back_pressure();
    test_drop_err();
    test_start_clears();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
